// File: rtl/onehot_grant_dispatcher.sv
// rtl/onehot_grant_dispatcher.sv - FIFO-buffered binary index to held one-hot grant dispatcher
module onehot_grant_dispatcher #(
  parameter int n     = 4,
  parameter int DEPTH = 2,
  localparam int W    = $clog2(n),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in_code,
  output logic          in_ready,
  input  logic [n-1:0]  ack,
  output logic [n-1:0]  grant,
  output logic          busy,
  output logic [LW-1:0] level,
  output logic          err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [W:0]    N_L     = (W + 1)'(n);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [n-1:0]   grant_q, grant_d;
  logic [LW-1:0]  level_q, level_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           err_q, err_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic [W-1:0]   mem_d [DEPTH];

  logic           push;
  logic           in_ok;
  logic           wr;
  logic           pop;
  logic           ack_hit;
  logic           not_empty;
  logic [W-1:0]   head;
  logic [n-1:0]   head_onehot;

  // Handshake and range qualification of the incoming code
  always_comb begin
    in_ready  = (level_q != DEPTH_L);
    push      = in_valid && in_ready;
    in_ok     = ({1'b0, in_code} < N_L);
    wr        = push && in_ok;
    not_empty = (level_q != '0);
    head      = mem_q[rd_ptr_q];
    ack_hit   = |(ack & grant_q);
  end

  // Decode the FIFO head into its one-hot line; stored codes are always < n
  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < n; i++) begin
      if (head == W'(i)) begin
        head_onehot[i] = 1'b1;
      end
    end
  end

  // Grant FSM: load from the FIFO when idle, hold until the granted line acks
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          grant_d = head_onehot;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ack_hit) begin
          if (not_empty) begin
            pop     = 1'b1;
            grant_d = head_onehot;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO storage, pointers, occupancy and sticky range error
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    err_d    = err_q | (push && !in_ok);
    if (wr) begin
      mem_d[wr_ptr_q] = in_code;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (wr && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!wr && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // State registers; reset discards buffered codes and drops the grant at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    grant = grant_q;
    busy  = (state_q == GRANT);
    level = level_q;
    err   = err_q;
  end

endmodule

// File: doc/onehot_grant_dispatcher.md
Name: onehot_grant_dispatcher

Overview:
Sequential counterpart of the codebase's priority encoders. It accepts a binary line index from an encoder stage, buffers it in a small FIFO, and drives the matching one-hot grant line. Each grant is held until the addressed consumer acknowledges it. It sits between an encoder-based request selector and N single-line consumers.

Parameters:
n, 4, number of one-hot output lines; must be >= 2.
DEPTH, 2, FIFO depth in entries; power of 2, must be >= 2.
W, $clog2(n), index width; local, not overridable.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_code is valid this cycle.
in_code  input  W  binary line index.
in_ready  output  1  FIFO can accept; equals !full.
ack  input  n  per-line acknowledge from consumers.
grant  output  n  one-hot grant, or all zero.
busy  output  1  a grant is currently asserted.
level  output  $clog2(DEPTH)+1  FIFO occupancy.
err  output  1  sticky flag: an out-of-range code was received.

Behaviour:
- Reset (async assert, sync release, all outputs registered or derived from registers):
  - grant=0, busy=0, level=0, err=0, in_ready=1.
  - FIFO pointers cleared; state=IDLE.
- Reset mid-grant: grant drops immediately and all buffered codes are discarded.
- Accept: a handshake occurs at a rising edge when in_valid && in_ready.
  - in_ready = (level != DEPTH). There is no bypass: when full, nothing is accepted, even if a pop happens in the same cycle.
- Range check on an accepted code:
  - If in_code >= n (possible only when n is not a power of 2), the code is consumed but not written.
  - err is set at that edge and stays at 1 until reset; level does not change.
- FSM, two states:
  - IDLE: if level>0 at the edge, pop the head; grant <= (1 << head); state -> GRANT.
  - GRANT: grant is held stable. When ack[g]=1 for the granted index g:
    - if level>0, pop and load the next grant at the same edge (back-to-back, no idle cycle), stay in GRANT;
    - otherwise grant <= 0 and state -> IDLE.
- ack bits on non-granted lines are ignored. ack in IDLE is ignored.
- Latency: a code accepted at edge t into an empty FIFO in IDLE produces grant at edge t+1. level shows 1 for the cycle after t.
- Simultaneous push and pop: level is unchanged; the pop takes the older entry (FIFO order).
- Pointers wrap modulo DEPTH. level = number of written entries minus popped entries, and never exceeds DEPTH.
- busy = (state==GRANT). Invariant: grant != 0 exactly when busy=1, and grant is always one-hot or zero.
- Duplicate codes are legal; each one is granted separately.

Test Plan:
- Reset then single code: in_code=2 accepted at edge 1 -> grant=4'b0100 after edge 2, busy=1; ack=4'b0100 at edge 5 -> grant=0, busy=0 after edge 5.
- Fill: codes 1,3 pushed with no ack -> after the first pop level=1. Push 0 -> level=2, in_ready=0, and further in_valid is not accepted. Ack each line in turn -> grants 0010, 1000, 0001 back-to-back, no idle cycle.
- Wrong-line ack: grant=0010, ack=1101 held 3 cycles -> grant unchanged; then ack=0010 -> grant clears.
- Out-of-range with n=5 (W=3): in_code=6 -> in_ready stays 1, level stays 0, err=1 from the next cycle; a following code 4 -> grant=5'b10000, err still 1.
- Simultaneous push/pop: level=1 in GRANT, ack and a new push on the same edge -> level stays 1 and the next grant is the older entry.
- Async reset mid-grant with level=2: rst_n low between edges -> grant=0, level=0, in_ready=1 immediately. After release, no grant appears without new input.
